// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ packet sources
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [IW-1:0]                 grant_id,
  output logic [15:0]                   beat_count
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_grant_id, r_last_grant, w_winner;
  logic [15:0] r_beat_count;
  logic w_burst, w_accept;
  logic [DATA_WIDTH-1:0] w_beats [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_beats[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // search starts just after the last completed owner, ascending with wrap
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] last);
    logic [IW-1:0] w;
    logic hit;
    w = last;
    hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (int'(last) + k) % NUM_REQ;
      if (!hit && v[j]) begin
        w = IW'(j);
        hit = 1'b1;
      end
    end
    return w;
  endfunction
  assign w_winner = rr_pick(req_valid, r_last_grant);
  assign w_burst = r_state == BURST;
  assign w_accept = w_burst & req_valid[r_grant_id] & ~fifo_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant_id <= '0;
      r_beat_count <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      if (!w_burst && |req_valid) begin
        r_grant_id <= w_winner;
        r_beat_count <= '0;
      end
      if (w_accept) begin
        r_beat_count <= r_beat_count + {15'd0, r_beat_count != 16'hFFFF};
        if (req_last[r_grant_id]) r_last_grant <= r_grant_id;
      end
    end
  end
  always_comb begin
    w_next = w_burst ? ((w_accept && req_last[r_grant_id]) ? IDLE : BURST) : ((|req_valid) ? BURST : IDLE);
  end
  // reset gates the strobes combinationally so a cut packet never writes in the reset cycle
  always_comb begin
    fifo_wr_en = w_accept & ~reset;
    req_ready = (w_burst && !fifo_full && !reset) ? NUM_REQ'(1) << r_grant_id : '0;
    fifo_wr_data = w_burst ? w_beats[r_grant_id] : '0;
  end
  assign grant_valid = w_burst;
  assign grant_id = r_grant_id;
  assign beat_count = r_beat_count;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table plus directed multi-cycle sequences for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic fifo_full, fifo_wr_en, grant_valid;
  logic [7:0] fifo_wr_data;
  logic [1:0] grant_id;
  logic [15:0] beat_count;
  int checks = 0;
  int failures = 0;
  logic [7:0] wq[$];
  typedef struct {
    logic rst; logic [3:0] v; logic [3:0] l; logic [31:0] d; logic full;
    logic chk_st; logic we; logic [7:0] wd; logic [3:0] rdy; logic gv; logic [1:0] gid; logic [15:0] bc;
  } vec_t;
  vec_t tv[$];
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .beat_count(beat_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l, logic [31:0] d, logic full,
                              logic cs, logic we, logic [7:0] wd, logic [3:0] rdy, logic gv, logic [1:0] gid, logic [15:0] bc);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.d = d; t.full = full;
    t.chk_st = cs; t.we = we; t.wd = wd; t.rdy = rdy; t.gv = gv; t.gid = gid; t.bc = bc;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic full);
    @(negedge clk);
    reset = rst; req_valid = v; req_last = l; req_data = d; fifo_full = full;
    #1;
    if (fifo_wr_en) wq.push_back(fifo_wr_data);
  endtask
  task automatic chk_q(input string nm, input int n, input logic [31:0] e);
    chk({nm, ".count"}, wq.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.beat%0d", nm, i), (i < wq.size()) ? {24'd0, wq[i]} : 32'hFFFF_FFFF, {24'd0, e[i*8 +: 8]});
    wq.delete();
  endtask
  initial begin
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    tv.push_back(mk(1, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 1, 8'hA0, 4'h1, 1, 0, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 1));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 1, 8'hA1, 4'h2, 1, 1, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 1, 1));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 1, 8'hA2, 4'h4, 1, 2, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 2, 1));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 1, 8'hA3, 4'h8, 1, 3, 0));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 3, 1));
    tv.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1, 1, 8'hA0, 4'h1, 1, 0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 32'hA3A2A1A0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 1));
    tv.push_back(mk(0, 4'h6, 4'h4, 32'h00211100, 0, 1, 0, 8'h00, 4'h0, 0, 0, 1));
    tv.push_back(mk(0, 4'h6, 4'h4, 32'h00211100, 0, 1, 1, 8'h11, 4'h2, 1, 1, 0));
    tv.push_back(mk(0, 4'h6, 4'h4, 32'h00211200, 0, 1, 1, 8'h12, 4'h2, 1, 1, 1));
    tv.push_back(mk(0, 4'h6, 4'h6, 32'h00211300, 0, 1, 1, 8'h13, 4'h2, 1, 1, 2));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00210000, 0, 1, 0, 8'h00, 4'h0, 0, 1, 3));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00210000, 0, 1, 1, 8'h21, 4'h4, 1, 2, 0));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00300000, 0, 1, 0, 8'h00, 4'h0, 0, 2, 1));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00300000, 0, 1, 1, 8'h30, 4'h4, 1, 2, 0));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00310000, 0, 1, 0, 8'h00, 4'h0, 0, 2, 1));
    tv.push_back(mk(0, 4'h4, 4'h4, 32'h00310000, 0, 1, 1, 8'h31, 4'h4, 1, 2, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 32'h00000000, 0, 1, 0, 8'h00, 4'h0, 0, 2, 1));
    foreach (tv[n]) begin
      drive(tv[n].rst, tv[n].v, tv[n].l, tv[n].d, tv[n].full);
      chk($sformatf("v%0d.wr_en", n), fifo_wr_en, tv[n].we);
      chk($sformatf("v%0d.ready", n), req_ready, tv[n].rdy);
      if (tv[n].we || (tv[n].chk_st && !tv[n].gv)) chk($sformatf("v%0d.wr_data", n), fifo_wr_data, tv[n].wd);
      if (tv[n].chk_st) begin
        chk($sformatf("v%0d.grant_valid", n), grant_valid, tv[n].gv);
        chk($sformatf("v%0d.grant_id", n), grant_id, tv[n].gid);
        chk($sformatf("v%0d.beat_count", n), beat_count, tv[n].bc);
      end
    end
    wq.delete();
    // fifo_full stall of 5 cycles inside a 3-beat packet from requester 0
    drive(0, 4'h1, 4'h0, 32'h51, 0); chk("t3.idle_gv", grant_valid, 0);
    drive(0, 4'h1, 4'h0, 32'h51, 0); chk("t3.b1_we", fifo_wr_en, 1); chk("t3.b1_gid", grant_id, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'h1, 4'h0, 32'h52, 1);
      chk($sformatf("t3.full%0d_we", i), fifo_wr_en, 0);
      chk($sformatf("t3.full%0d_rdy", i), req_ready, 0);
      chk($sformatf("t3.full%0d_gv", i), grant_valid, 1);
      chk($sformatf("t3.full%0d_gid", i), grant_id, 0);
    end
    drive(0, 4'h1, 4'h0, 32'h52, 0); chk("t3.b2_we", fifo_wr_en, 1);
    drive(0, 4'h1, 4'h1, 32'h53, 0); chk("t3.b3_we", fifo_wr_en, 1);
    drive(0, 4'h0, 4'h0, 32'h0, 0); chk("t3.end_gv", grant_valid, 0); chk("t3.end_bc", beat_count, 3);
    chk_q("t3.fifo", 3, 32'h00535251);
    // requester 3 pauses mid-packet while requester 0 waits
    drive(0, 4'h9, 4'h1, 32'h61000071, 0); chk("t4.idle_gv", grant_valid, 0);
    drive(0, 4'h9, 4'h1, 32'h61000071, 0); chk("t4.b1_gid", grant_id, 3); chk("t4.b1_we", fifo_wr_en, 1);
    chk("t4.b1_rdy", req_ready, 4'h8);
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'h1, 4'h1, 32'h62000071, 0);
      chk($sformatf("t4.gap%0d_we", i), fifo_wr_en, 0);
      chk($sformatf("t4.gap%0d_gid", i), grant_id, 3);
      chk($sformatf("t4.gap%0d_rdy", i), req_ready, 4'h8);
    end
    drive(0, 4'h9, 4'h9, 32'h62000071, 0); chk("t4.b2_we", fifo_wr_en, 1);
    drive(0, 4'h1, 4'h1, 32'h00000071, 0); chk("t4.bubble_gv", grant_valid, 0);
    drive(0, 4'h1, 4'h1, 32'h00000071, 0); chk("t4.next_gid", grant_id, 0); chk("t4.next_we", fifo_wr_en, 1);
    drive(0, 4'h0, 4'h0, 32'h0, 0); chk("t4.end_gv", grant_valid, 0);
    chk_q("t4.fifo", 3, 32'h00716261);
    // reset cuts beat 2 of a requester-2 packet; pointer returns to requester 0
    drive(0, 4'h4, 4'h0, 32'h00810000, 0); chk("t5.idle_gv", grant_valid, 0);
    drive(0, 4'h4, 4'h0, 32'h00810000, 0); chk("t5.b1_gid", grant_id, 2); chk("t5.b1_we", fifo_wr_en, 1);
    drive(1, 4'h4, 4'h0, 32'h00820000, 0); chk("t5.rst_we", fifo_wr_en, 0); chk("t5.rst_rdy", req_ready, 0);
    drive(0, 4'h5, 4'h5, 32'h00830091, 0); chk("t5.post_gv", grant_valid, 0); chk("t5.post_gid", grant_id, 0);
    chk("t5.post_bc", beat_count, 0);
    drive(0, 4'h5, 4'h5, 32'h00830091, 0); chk("t5.win_gid", grant_id, 0); chk("t5.win_we", fifo_wr_en, 1);
    drive(0, 4'h4, 4'h4, 32'h00830000, 0); chk("t5.bubble_gv", grant_valid, 0);
    drive(0, 4'h4, 4'h4, 32'h00830000, 0); chk("t5.r2_gid", grant_id, 2); chk("t5.r2_we", fifo_wr_en, 1);
    drive(0, 4'h0, 4'h0, 32'h0, 0); chk("t5.end_gv", grant_valid, 0);
    chk_q("t5.fifo", 3, 32'h00839181);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
